// File: rtl/deser_pkg.sv
// Shared constants and FSM state type for the serial word deserializer.
package deser_pkg;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_NUM_WORDS = 8;
    localparam int DEF_IDX_W     = $clog2(DEF_NUM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } deser_state_t;

endpackage

// File: rtl/deser_if.sv
// Word output port of the deserializer: data, index and valid/ready handshake.
interface deser_if #(
    parameter int WORD_W = deser_pkg::DEF_WORD_W,
    parameter int IDX_W  = deser_pkg::DEF_IDX_W
);

    logic [WORD_W-1:0] WORD_OUT;
    logic [IDX_W-1:0]  WORD_IDX;
    logic              WORD_VALID;
    logic              WORD_READY;

    modport master (
        output WORD_OUT,
        output WORD_IDX,
        output WORD_VALID,
        input  WORD_READY
    );

    modport slave (
        input  WORD_OUT,
        input  WORD_IDX,
        input  WORD_VALID,
        output WORD_READY
    );

endinterface

// File: rtl/deser_word_shifter.sv
// LSB-first shift register with bit counter; flags the cycle a word's last bit arrives.
module deser_word_shifter #(
    parameter int WORD_W = deser_pkg::DEF_WORD_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_shift,
    input  logic              i_restart,
    input  logic              i_bit,
    output logic              o_word_done,
    output logic [WORD_W-1:0] o_word
);

    localparam int CNT_W = $clog2(WORD_W);

    logic [WORD_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_cnt;

    // A restart makes this cycle's bit (if any) bit 0 of a fresh word.
    assign w_cnt       = i_restart ? '0 : r_bit_cnt;
    assign o_word_done = i_shift && (w_cnt == CNT_W'(WORD_W - 1));
    assign o_word      = {i_bit, r_sh[WORD_W-1:1]};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sh      <= '0;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_sh      <= o_word;
            r_bit_cnt <= o_word_done ? '0 : w_cnt + 1'b1;
        end else if (i_restart) begin
            r_bit_cnt <= '0;
        end
    end

endmodule

// File: rtl/deserializer_unit_cell.sv
// Frame deserializer: rebuilds NUM_WORDS words from a 1-bit LSB-first stream.
module deserializer_unit_cell
    import deser_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic     CLK,
    input  logic     RESET,
    input  logic     SER_IN,
    input  logic     SER_VALID,
    input  logic     FRAME_START,
    deser_if.master  wport,
    output logic     FRAME_DONE,
    output logic     OVERFLOW,
    output logic     BUSY
);

    deser_state_t      r_state;
    logic [IDX_W-1:0]  r_word_cnt;
    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic              r_valid;
    logic              r_fd;
    logic              r_ovf;

    logic              w_shift;
    logic              w_done;
    logic [WORD_W-1:0] w_word;
    logic              w_last;
    logic              w_accept;
    logic              w_load;

    assign w_shift  = SER_VALID && (FRAME_START || r_state == RECV);
    assign w_last   = (r_word_cnt == IDX_W'(NUM_WORDS - 1));
    assign w_accept = r_valid && wport.WORD_READY;
    // A word completing while the held one is stalled is dropped.
    assign w_load   = w_done && (!r_valid || wport.WORD_READY);

    deser_word_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .CLK         (CLK),
        .RESET       (RESET),
        .i_shift     (w_shift),
        .i_restart   (FRAME_START),
        .i_bit       (SER_IN),
        .o_word_done (w_done),
        .o_word      (w_word)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_word     <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_fd       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (FRAME_START)
                        r_state <= RECV;
                end
                RECV: begin
                    if (!FRAME_START && w_done && w_last)
                        r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase

            if (FRAME_START)
                r_word_cnt <= '0;
            else if (w_done)
                r_word_cnt <= w_last ? '0 : r_word_cnt + 1'b1;

            if (w_load) begin
                r_word  <= w_word;
                r_idx   <= r_word_cnt;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            r_fd <= w_done && w_last;

            if (FRAME_START)
                r_ovf <= 1'b0;
            else if (w_done && !w_load)
                r_ovf <= 1'b1;
        end
    end

    assign wport.WORD_OUT   = r_word;
    assign wport.WORD_IDX   = r_idx;
    assign wport.WORD_VALID = r_valid;
    assign FRAME_DONE       = r_fd;
    assign OVERFLOW         = r_ovf;
    assign BUSY             = (r_state == RECV);

endmodule

// File: tb/tb_deserializer_unit_cell.sv
// Self-checking bench: frame-level reference model plus directed and random stimulus.
module tb_deserializer_unit_cell;

    import deser_pkg::*;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic SER_IN = 1'b0;
    logic SER_VALID = 1'b0;
    logic FRAME_START = 1'b0;
    logic FRAME_DONE;
    logic OVERFLOW;
    logic BUSY;

    deser_if wif ();

    deserializer_unit_cell dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SER_IN      (SER_IN),
        .SER_VALID   (SER_VALID),
        .FRAME_START (FRAME_START),
        .wport       (wif),
        .FRAME_DONE  (FRAME_DONE),
        .OVERFLOW    (OVERFLOW),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;

    logic [31:0] got_w[$];
    logic [2:0]  got_i[$];

    logic [31:0] F1 [8] = '{
        32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1234_5678,
        32'hFFFF_FFFF, 32'h0000_0000, 32'hA5A5_A5A5, 32'h5A5A_5A5A
    };

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: frame position as plain integers, word built bit by bit.
    int          m_st;
    int          m_pos;
    int          m_widx;
    logic [31:0] m_acc;
    logic [31:0] e_word;
    logic [2:0]  e_idx;
    logic        e_valid;
    logic        e_fd;
    logic        e_ovf;
    logic        e_busy;

    task automatic m_clear();
        m_st = 0; m_pos = 0; m_widx = 0; m_acc = '0;
        e_word = '0; e_idx = '0; e_valid = 0;
        e_fd = 0; e_ovf = 0; e_busy = 0;
    endtask

    task automatic m_step();
        bit done;
        bit accepted;
        accepted = e_valid && wif.WORD_READY;
        done = 0;
        e_fd = 0;
        if (FRAME_START) begin
            m_st = 1; m_pos = 0; m_widx = 0; e_ovf = 0;
        end
        if (SER_VALID && m_st == 1) begin
            m_acc[m_pos] = SER_IN;
            m_pos++;
            if (m_pos == 32) begin
                done = 1;
                m_pos = 0;
            end
        end
        if (done) begin
            if (!e_valid || accepted) begin
                e_word = m_acc;
                e_idx = m_widx[2:0];
                e_valid = 1;
            end else begin
                e_ovf = 1;
            end
            if (m_widx == 7) begin
                e_fd = 1;
                m_st = 2;
            end
            m_widx = (m_widx + 1) % 8;
        end else if (accepted) begin
            e_valid = 0;
        end
        e_busy = (m_st == 1);
    endtask

    initial m_clear();
    always @(negedge RESET) m_clear();
    always @(posedge CLK) begin
        if (RESET) m_step();
        else m_clear();
    end

    always @(negedge CLK) begin
        chk("word_valid", wif.WORD_VALID, e_valid);
        if (e_valid) begin
            chk("word_out", wif.WORD_OUT, e_word);
            chk("word_idx", wif.WORD_IDX, e_idx);
        end
        chk("frame_done", FRAME_DONE, e_fd);
        chk("overflow", OVERFLOW, e_ovf);
        chk("busy", BUSY, e_busy);
        if (FRAME_DONE) fd_cnt++;
        if (wif.WORD_VALID && wif.WORD_READY) begin
            got_w.push_back(wif.WORD_OUT);
            got_i.push_back(wif.WORD_IDX);
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic drive(input logic b, input logic v, input logic fs);
        tick();
        SER_IN = b;
        SER_VALID = v;
        FRAME_START = fs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit fs, input bit gaps);
        for (int k = 0; k < 32; k++) begin
            drive(w[k], 1'b1, fs && k == 0);
            if (gaps) drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 8; i++) send_word(F1[i], i == 0, gaps);
    endtask

    task automatic clr_got();
        got_w.delete();
        got_i.delete();
    endtask

    initial begin
        int n;
        logic [31:0] w;
        wif.WORD_READY = 1'b1;
        repeat (3) tick();
        chk("rst_valid", wif.WORD_VALID, 0);
        chk("rst_word", wif.WORD_OUT, 0);
        chk("rst_busy", BUSY, 0);
        RESET = 1'b1;
        idle(2);

        clr_got();
        send_frame(0);
        idle(4);
        chk("t1_count", got_w.size(), 8);
        for (int i = 0; i < 8 && i < got_w.size(); i++) begin
            chk("t1_word", got_w[i], F1[i]);
            chk("t1_idx", got_i[i], i);
        end
        chk("t1_fd", fd_cnt, 1);
        chk("t1_busy", BUSY, 0);

        clr_got();
        send_frame(1);
        idle(4);
        chk("t2_count", got_w.size(), 8);
        for (int i = 0; i < 8 && i < got_w.size(); i++)
            chk("t2_word", got_w[i], F1[i]);
        chk("t2_ovf", OVERFLOW, 0);

        clr_got();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            w = F1[i];
            for (int k = 0; k < 32; k++) begin
                tick();
                if (n == 70) begin
                    chk("t3_held", wif.WORD_OUT, 32'h0000_0001);
                    chk("t3_hidx", wif.WORD_IDX, 0);
                    chk("t3_ovf", OVERFLOW, 1);
                end
                wif.WORD_READY = !(n >= 32 && n < 72);
                SER_IN = w[k];
                SER_VALID = 1'b1;
                FRAME_START = (n == 0);
                n++;
            end
        end
        idle(4);
        chk("t3_count", got_w.size(), 7);
        if (got_w.size() >= 2) begin
            chk("t3_w0", got_w[0], 32'h0000_0001);
            chk("t3_i1", got_i[1], 2);
        end
        chk("t3_sticky", OVERFLOW, 1);
        drive(1'b0, 1'b0, 1'b1);
        idle(1);
        chk("t3_clear", OVERFLOW, 0);

        clr_got();
        for (int i = 0; i < 3; i++) send_word(F1[i], i == 0, 0);
        w = F1[3];
        for (int k = 0; k < 17; k++) drive(w[k], 1'b1, 1'b0);
        send_frame(0);
        idle(4);
        chk("t4_count", got_w.size(), 11);
        if (got_w.size() >= 4) begin
            chk("t4_idx", got_i[3], 0);
            chk("t4_word", got_w[3], F1[0]);
        end

        wif.WORD_READY = 1'b0;
        for (int i = 0; i < 5; i++) send_word(F1[i], i == 0, 0);
        w = F1[5];
        for (int k = 0; k < 10; k++) drive(w[k], 1'b1, 1'b0);
        tick();
        chk("t5_pre", wif.WORD_VALID, 1);
        RESET = 1'b0;
        #1;
        chk("t5_valid", wif.WORD_VALID, 0);
        chk("t5_word", wif.WORD_OUT, 0);
        chk("t5_idx", wif.WORD_IDX, 0);
        chk("t5_ovf", OVERFLOW, 0);
        chk("t5_busy", BUSY, 0);
        tick();
        RESET = 1'b1;
        wif.WORD_READY = 1'b1;
        for (int k = 0; k < 40; k++) drive(1'b1, 1'b1, 1'b0);
        idle(2);
        chk("t5_ign", wif.WORD_VALID, 0);

        send_frame(0);
        idle(4);
        clr_got();
        for (int k = 0; k < 64; k++) drive(1'($urandom), 1'b1, 1'b0);
        idle(2);
        chk("t6_none", got_w.size(), 0);
        chk("t6_busy", BUSY, 0);
        send_frame(0);
        idle(4);
        chk("t6_count", got_w.size(), 8);
        if (got_w.size() >= 1) chk("t6_idx0", got_i[0], 0);

        drive(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            tick();
            wif.WORD_READY = ($urandom_range(0, 3) != 0);
            SER_IN = 1'($urandom);
            SER_VALID = ($urandom_range(0, 3) != 0);
            FRAME_START = ($urandom_range(0, 299) == 0);
        end
        wif.WORD_READY = 1'b1;
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
